// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared defaults and helpers for the sync_fifo_flags FIFO.
//   - default width/depth localparams
//   - ptr_w(): address width for a given depth
//   - fifo_flags_t / FLAGS_RST: status flag bundle and its value at count==0
package sync_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 16;

  // Address bits needed to index DEPTH entries (at least 1).
  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  // Flags for an empty FIFO; this is what reset produces since count==0.
  localparam fifo_flags_t FLAGS_RST = '{full: 1'b0, empty: 1'b1,
                                        almost_full: 1'b0, almost_empty: 1'b1};

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: simple dual-port storage, DATA_WIDTH x DEPTH, no reset.
//   clk    : clock
//   we     : write enable, writes wdata to mem[waddr]
//   re     : read enable, registers mem[raddr] onto rdata (1-cycle latency)
//   rdata  : registered read data, holds when re is low
// A read and write to the same address in one cycle returns the old word.
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and a read-valid strobe.
//   clk, rst_n   : clock, asynchronous active-low reset
//   w_en, w_data : write request and data
//   r_en         : read request
//   r_data       : registered read data (1-cycle latency), r_valid strobes
//   full/empty/almost_full/almost_empty/count : status from the pointers
// Optional macro SYNC_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow
// outputs, set by ignored writes/reads and cleared only by reset.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int PTR_WIDTH  = ptr_w(DEPTH),
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PTR_WIDTH:0]    count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam logic [PTR_WIDTH:0] DEPTH_C = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] AF_C    = (PTR_WIDTH+1)'(AF_THRESH);
  localparam logic [PTR_WIDTH:0] AE_C    = (PTR_WIDTH+1)'(AE_THRESH);

  logic [PTR_WIDTH:0]    w_ptr_q, w_ptr_d;
  logic [PTR_WIDTH:0]    r_ptr_q, r_ptr_d;
  logic                  r_valid_q, r_valid_d;
  // The RAM read register has no reset; this masks it to 0 until the
  // first read after reset so r_data reads 0 out of reset.
  logic                  rd_seen_q, rd_seen_d;
  logic [PTR_WIDTH:0]    cnt;
  fifo_flags_t           flags;
  logic                  wr_ok, rd_ok;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Wrap bit in the MSB makes the modular difference the true occupancy.
  assign cnt = w_ptr_q - r_ptr_q;

  always_comb begin
    flags              = FLAGS_RST;
    flags.full         = (cnt == DEPTH_C);
    flags.empty        = (cnt == '0);
    flags.almost_full  = (cnt >= AF_C);
    flags.almost_empty = (cnt <= AE_C);
  end

  // A read frees a slot in the same cycle, so a write at full is taken
  // when paired with a read; at empty the read is refused (no bypass).
  assign rd_ok = r_en && !flags.empty;
  assign wr_ok = w_en && (!flags.full || rd_ok);

  always_comb begin
    w_ptr_d   = w_ptr_q;
    r_ptr_d   = r_ptr_q;
    r_valid_d = rd_ok;
    rd_seen_d = rd_seen_q | rd_ok;
    if (wr_ok) w_ptr_d = w_ptr_q + 1'b1;
    if (rd_ok) r_ptr_d = r_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr_q   <= '0;
      r_ptr_q   <= '0;
      r_valid_q <= 1'b0;
      rd_seen_q <= 1'b0;
    end else begin
      w_ptr_q   <= w_ptr_d;
      r_ptr_q   <= r_ptr_d;
      r_valid_q <= r_valid_d;
      rd_seen_q <= rd_seen_d;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (PTR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (w_ptr_q[PTR_WIDTH-1:0]),
    .wdata (w_data),
    .re    (rd_ok),
    .raddr (r_ptr_q[PTR_WIDTH-1:0]),
    .rdata (ram_rdata)
  );

  assign r_data       = rd_seen_q ? ram_rdata : '0;
  assign r_valid      = r_valid_q;
  assign count        = cnt;
  assign full         = flags.full;
  assign empty        = flags.empty;
  assign almost_full  = flags.almost_full;
  assign almost_empty = flags.almost_empty;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q | (w_en && flags.full && !rd_ok);
    udf_d = udf_q | (r_en && flags.empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags (DEPTH=16, thresholds 14/2): a vector
// table for fill/drain and boundary cases, plus sequences for wrap-around
// and asynchronous reset. Builds with or without SYNC_FIFO_ERR_FLAGS_EN.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       w_en = 1'b0;
  logic [7:0] w_data = '0;
  logic       r_en = 1'b0;
  logic [7:0] r_data;
  logic       r_valid, full, empty, almost_full, almost_empty;
  logic [4:0] count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic       overflow, underflow;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .w_en         (w_en),
    .w_data       (w_data),
    .r_en         (r_en),
    .r_data       (r_data),
    .r_valid      (r_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  typedef struct {
    logic       we, re;
    logic [7:0] wd;
    logic [4:0] cnt;
    logic       rv;
    logic [7:0] rd;
    logic       ovf, udf;
  } vec_t;

  vec_t tbl [64];
  int   nv = 0;
  logic [7:0] last_rd = 8'h00;
  logic cur_ovf = 1'b0, cur_udf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Flags are checked against the occupancy the bench expects.
  task automatic chk_status(input string tag, input logic [4:0] c);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".full"}, 32'(full), 32'(c == 5'd16));
    chk({tag, ".empty"}, 32'(empty), 32'(c == 5'd0));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(c >= 5'd14));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(c <= 5'd2));
  endtask

  task automatic add(input logic we, input logic re, input logic [7:0] wd,
                     input logic [4:0] cnt, input logic rv, input logic [7:0] rd);
    if (rv) last_rd = rd;
    tbl[nv] = '{we: we, re: re, wd: wd, cnt: cnt, rv: rv, rd: last_rd,
                ovf: cur_ovf, udf: cur_udf};
    nv++;
  endtask

  task automatic step(input logic we, input logic re, input logic [7:0] wd);
    w_en = we; r_en = re; w_data = wd;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    w_en = 1'b0; r_en = 1'b0;
    rst_n = 1'b0; #3; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  logic [7:0] q [$];
  int         mcnt;
  logic [7:0] exp_rd;

  initial begin
    // ---- vector table: fill, full boundary, drain, empty boundary ----
    for (int i = 0; i < 16; i++) add(1'b1, 1'b0, 8'(i), 5'(i + 1), 1'b0, 8'h00);
    cur_ovf = 1'b1;
    add(1'b1, 1'b0, 8'hEE, 5'd16, 1'b0, 8'h00);            // write at full: ignored
    add(1'b1, 1'b1, 8'hA5, 5'd16, 1'b1, 8'h00);            // full + rd/wr
    for (int i = 1; i < 16; i++) add(1'b0, 1'b1, 8'h00, 5'(16 - i), 1'b1, 8'(i));
    add(1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 8'hA5);             // A5 comes out last
    cur_udf = 1'b1;
    add(1'b0, 1'b1, 8'h00, 5'd0, 1'b0, 8'h00);             // read at empty: ignored
    add(1'b1, 1'b1, 8'h3C, 5'd1, 1'b0, 8'h00);             // empty + rd/wr: no bypass
    add(1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 8'h00);
    add(1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 8'h3C);

    // ---- reset state ----
    #12;
    chk_status("rst0", 5'd0);
    chk("rst0.r_valid", 32'(r_valid), 32'd0);
    chk("rst0.r_data", 32'(r_data), 32'd0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("rst0.overflow", 32'(overflow), 32'd0);
    chk("rst0.underflow", 32'(underflow), 32'd0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < nv; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(tbl[i].we, tbl[i].re, tbl[i].wd);
      chk_status(tag, tbl[i].cnt);
      chk({tag, ".r_valid"}, 32'(r_valid), 32'(tbl[i].rv));
      chk({tag, ".r_data"}, 32'(r_data), 32'(tbl[i].rd));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      chk({tag, ".overflow"}, 32'(overflow), 32'(tbl[i].ovf));
      chk({tag, ".underflow"}, 32'(underflow), 32'(tbl[i].udf));
`endif
    end

    // ---- sticky error flags clear only on reset ----
    do_reset();
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("errclr.overflow", 32'(overflow), 32'd0);
    chk("errclr.underflow", 32'(underflow), 32'd0);
`endif

    // ---- wrap-around: count held in 5..12, scoreboard checks order ----
    q.delete();
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, 8'h40 + 8'(k));
      q.push_back(8'h40 + 8'(k));
    end
    chk_status("wrap.pre", 5'd8);
    for (int i = 0; i < 40; i++) begin
      logic we, re;
      logic [7:0] d;
      mcnt = q.size();
      we = 1'b1; re = 1'b1;
      if ((i % 4) == 2 && mcnt < 12) re = 1'b0;
      if ((i % 4) == 3 && mcnt > 5)  we = 1'b0;
      d = 8'h80 + 8'(i);
      step(we, re, d);
      if (re) exp_rd = q.pop_front();
      if (we) q.push_back(d);
      chk_status($sformatf("wrap%0d", i), 5'(q.size()));
      chk($sformatf("wrap%0d.r_valid", i), 32'(r_valid), 32'(re));
      if (re) chk($sformatf("wrap%0d.r_data", i), 32'(r_data), 32'(exp_rd));
    end
    while (q.size() > 0) begin
      exp_rd = q.pop_front();
      step(1'b0, 1'b1, 8'h00);
      chk("wrap.drain.r_data", 32'(r_data), 32'(exp_rd));
    end
    chk_status("wrap.end", 5'd0);

    // ---- asynchronous reset mid-stream with count=5 ----
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 8'h11 + 8'(k));
    step(1'b1, 1'b1, 8'h99);
    chk("arst.pre.r_valid", 32'(r_valid), 32'd1);
    chk("arst.pre.r_data", 32'(r_data), 32'h11);
    chk_status("arst.pre", 5'd5);
    w_en = 1'b0; r_en = 1'b0;
    rst_n = 1'b0;
    #1;                               // well before the next clk edge
    chk_status("arst", 5'd0);
    chk("arst.r_valid", 32'(r_valid), 32'd0);
    chk("arst.r_data", 32'(r_data), 32'd0);
    #1 rst_n = 1'b1;
    step(1'b0, 1'b1, 8'h00);          // stored words were discarded
    chk("arst.post.r_valid", 32'(r_valid), 32'd0);
    chk_status("arst.post", 5'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
